mbist_session_ctrl: RTL and testbench

MBIST_SESSION_CTRL -- requirements
Module: mbist_session_ctrl

---
 rtl/mbist_pkg.sv | 14 +
 rtl/mbist_timeout_cnt.sv | 32 +++
 rtl/mbist_session_ctrl.sv | 132 +++++++++++++
 tb/tb_mbist_session_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mbist_pkg.sv
// rtl/mbist_pkg.sv - shared state encoding and default sizing for the MBIST session controller
package mbist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_REPORT = 2'd3
  } state_t;

  localparam int unsigned TIMEOUT_CYC_DEF = 1024;
  localparam int unsigned CNT_W_DEF       = 8;

endpackage

// File: rtl/mbist_timeout_cnt.sv
// rtl/mbist_timeout_cnt.sv - WAIT-cycle timer; expired flags the TIMEOUT_CYC-th enabled cycle
import mbist_pkg::*;

module mbist_timeout_cnt #(
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYC - 1);

  logic [W-1:0] r_cnt;

  // r_cnt holds the number of enabled cycles already seen, so the terminal one is combinational
  assign expired = enable && (r_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (enable && !expired) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

endmodule

// File: rtl/mbist_session_ctrl.sv
// rtl/mbist_session_ctrl.sv - MBIST session sequencer: launch, wait for done/timeout, report
// Optional repair re-run after a first-attempt fail is enabled by defining SESSION_RETRY_EN.
import mbist_pkg::*;

module mbist_session_ctrl #(
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  output logic             bist_start,
  input  logic             bist_done,
  input  logic             bist_fail,
  output logic             busy,
  output logic             result_valid,
  output logic             result_pass,
  output logic             result_timeout,
  output logic             result_retried,
  output logic [CNT_W-1:0] run_cnt,
  output logic [CNT_W-1:0] fail_cnt
);

  state_t r_state;
  logic   r_done_prev;
  logic   r_pass;
  logic   r_timeout;
`ifdef SESSION_RETRY_EN
  logic   r_retried;
`endif

  logic w_done_edge;
  logic w_tmr_clear;
  logic w_tmr_en;
  logic w_expired;

  // Only a fresh rise counts, so a done level left high by a previous run cannot end this one
  assign w_done_edge = bist_done && !r_done_prev;
  assign w_tmr_clear = (r_state == ST_LAUNCH);
  assign w_tmr_en    = (r_state == ST_WAIT) && !w_done_edge;

  mbist_timeout_cnt #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (w_tmr_clear),
    .enable  (w_tmr_en),
    .expired (w_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_done_prev    <= 1'b0;
      r_pass         <= 1'b0;
      r_timeout      <= 1'b0;
`ifdef SESSION_RETRY_EN
      r_retried      <= 1'b0;
`endif
      bist_start     <= 1'b0;
      busy           <= 1'b0;
      result_valid   <= 1'b0;
      result_pass    <= 1'b0;
      result_timeout <= 1'b0;
      result_retried <= 1'b0;
      run_cnt        <= '0;
      fail_cnt       <= '0;
    end else begin
      r_done_prev <= bist_done;
      bist_start  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req) begin
            r_state      <= ST_LAUNCH;
            bist_start   <= 1'b1;
            busy         <= 1'b1;
            result_valid <= 1'b0;
`ifdef SESSION_RETRY_EN
            r_retried    <= 1'b0;
`endif
          end
        end
        ST_LAUNCH: begin
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (w_done_edge) begin
`ifdef SESSION_RETRY_EN
            if (bist_fail && !r_retried) begin
              r_retried  <= 1'b1;
              r_state    <= ST_LAUNCH;
              bist_start <= 1'b1;
            end else begin
              r_pass    <= !bist_fail;
              r_timeout <= 1'b0;
              r_state   <= ST_REPORT;
            end
`else
            r_pass    <= !bist_fail;
            r_timeout <= 1'b0;
            r_state   <= ST_REPORT;
`endif
          end else if (w_expired) begin
            r_pass    <= 1'b0;
            r_timeout <= 1'b1;
            r_state   <= ST_REPORT;
          end
        end
        ST_REPORT: begin
          result_valid   <= 1'b1;
          result_pass    <= r_pass;
          result_timeout <= r_timeout;
`ifdef SESSION_RETRY_EN
          result_retried <= r_retried;
`else
          result_retried <= 1'b0;
`endif
          if (run_cnt != '1) run_cnt <= run_cnt + CNT_W'(1);
          if (!r_pass && (fail_cnt != '1)) fail_cnt <= fail_cnt + CNT_W'(1);
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mbist_session_ctrl.sv
// tb/tb_mbist_session_ctrl.sv - randomized scoreboard bench for mbist_session_ctrl
module tb_mbist_session_ctrl;

  localparam int TMO = 16;
  localparam int CW  = 2;
  localparam int CMAX = (1 << CW) - 1;
`ifdef SESSION_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  typedef struct { int d; bit f; } attempt_t;
  typedef struct { bit pass; bit tmo; bit retr; int run; int fail; int starts; } result_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req;
  logic          bist_start;
  wire           bist_done;
  logic          bist_fail;
  logic          busy;
  logic          result_valid;
  logic          result_pass;
  logic          result_timeout;
  logic          result_retried;
  logic [CW-1:0] run_cnt;
  logic [CW-1:0] fail_cnt;

  logic done_pulse;
  logic hold_done;
  bit   resp_active;

  assign bist_done = done_pulse | hold_done;

  int n_cmp = 0;
  int n_err = 0;
  int mrun  = 0;
  int mfail = 0;

  attempt_t attq[$];
  result_t  sbq[$];

  always #5 clk = ~clk;

  mbist_session_ctrl #(
    .TIMEOUT_CYC (TMO),
    .CNT_W       (CW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req            (req),
    .bist_start     (bist_start),
    .bist_done      (bist_done),
    .bist_fail      (bist_fail),
    .busy           (busy),
    .result_valid   (result_valid),
    .result_pass    (result_pass),
    .result_timeout (result_timeout),
    .result_retried (result_retried),
    .run_cnt        (run_cnt),
    .fail_cnt       (fail_cnt)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // BIST-top stand-in: answers each start with the next queued attempt
  initial begin
    attempt_t a;
    done_pulse  = 1'b0;
    bist_fail   = 1'b0;
    resp_active = 1'b0;
    forever begin
      @(negedge clk);
      while (bist_start && rst_n) begin
        resp_active = 1'b1;
        if (attq.size() == 0) begin
          chk("unexpected_start", 1, 0);
          break;
        end
        a = attq.pop_front();
        if (a.d < 0) break;
        repeat (a.d) @(negedge clk);
        done_pulse = 1'b1;
        bist_fail  = a.f;
        @(negedge clk);
        done_pulse = 1'b0;
        bist_fail  = 1'b0;
      end
      resp_active = 1'b0;
    end
  end

  // Monitor: compares every newly presented result against the scoreboard
  initial begin
    result_t e;
    int  starts;
    bit  prev_valid;
    starts     = 0;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        starts     = 0;
        prev_valid = 1'b0;
      end else begin
        if (bist_start) starts++;
        if (result_valid && !prev_valid) begin
          if (sbq.size() == 0) begin
            chk("unexpected_result", 1, 0);
          end else begin
            e = sbq.pop_front();
            chk("result_pass",    32'(result_pass),    32'(e.pass));
            chk("result_timeout", 32'(result_timeout), 32'(e.tmo));
            chk("result_retried", 32'(result_retried), 32'(e.retr));
            chk("run_cnt",        32'(run_cnt),        e.run);
            chk("fail_cnt",       32'(fail_cnt),       e.fail);
            chk("start_pulses",   starts,              e.starts);
            chk("busy_after_rpt", 32'(busy),           0);
          end
          starts = 0;
        end
        prev_valid = result_valid;
      end
    end
  end

  task automatic wait_quiet(input string name);
    int i;
    for (i = 0; i < 300 && (sbq.size() != 0 || resp_active); i++) @(negedge clk);
    if (sbq.size() != 0 || resp_active) begin
      chk(name, 0, 1);
      sbq.delete();
    end
  endtask

  task automatic run_session(input bit held, input int d1, input bit f1,
                             input int d2, input bit f2, input int hold_extra);
    result_t e;
    e.retr   = 1'b0;
    e.starts = 1;
    if (held) begin
      attq.push_back('{d: -1, f: 1'b0});
      e.tmo  = 1'b1;
      e.pass = 1'b0;
    end else begin
      attq.push_back('{d: d1, f: f1});
      if (d1 > TMO) begin
        e.tmo  = 1'b1;
        e.pass = 1'b0;
      end else if (f1 && RETRY) begin
        e.retr   = 1'b1;
        e.starts = 2;
        attq.push_back('{d: d2, f: f2});
        e.tmo  = (d2 > TMO);
        e.pass = (d2 <= TMO) && !f2;
      end else begin
        e.tmo  = 1'b0;
        e.pass = !f1;
      end
    end
    mrun = (mrun == CMAX) ? CMAX : mrun + 1;
    if (!e.pass) mfail = (mfail == CMAX) ? CMAX : mfail + 1;
    e.run  = mrun;
    e.fail = mfail;
    sbq.push_back(e);

    if (held) begin
      hold_done = 1'b1;
      @(negedge clk);
    end
    req = 1'b1;
    @(negedge clk);
    chk("start_after_req", 32'(bist_start),   1);
    chk("busy_in_launch",  32'(busy),         1);
    chk("valid_cleared",   32'(result_valid), 0);
    repeat (hold_extra) @(negedge clk);
    req = 1'b0;
    wait_quiet("session_done_wait");
    hold_done = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int d1, d2, kind, hx;
    bit f1, f2;
    rst_n     = 1'b0;
    req       = 1'b0;
    hold_done = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_start",   32'(bist_start),   0);
    chk("rst_busy",    32'(busy),         0);
    chk("rst_valid",   32'(result_valid), 0);
    chk("rst_run_cnt", 32'(run_cnt),      0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("no_start_idle", 32'(bist_start), 0);

    run_session(1'b0, 10, 1'b0, 0, 1'b0, 0);
    run_session(1'b0, 12, 1'b1, 6, 1'b0, 1);
    run_session(1'b1, 0, 1'b0, 0, 1'b0, 2);
    run_session(1'b0, TMO, 1'b0, 0, 1'b0, 0);
    run_session(1'b0, TMO + 1, 1'b0, 0, 1'b0, 0);
    run_session(1'b0, 5, 1'b1, 8, 1'b1, 0);
    run_session(1'b0, 1, 1'b1, 1, 1'b0, 2);

    for (int s = 0; s < 40; s++) begin
      kind = $urandom_range(0, 9);
      d1 = $urandom_range(1, TMO + 4);
      d2 = $urandom_range(1, TMO + 4);
      if (kind == 1) d1 = TMO;
      if (kind == 2) d1 = TMO + 1;
      f1 = 1'($urandom_range(0, 1));
      f2 = 1'($urandom_range(0, 1));
      hx = $urandom_range(0, 2);
      run_session(kind == 0, d1, f1, d2, f2, hx);
    end

    // Reset in the middle of WAIT
    attq.push_back('{d: 30, f: 1'b0});
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    chk("start_before_rst", 32'(bist_start), 1);
    repeat (5) @(negedge clk);
    chk("busy_wait5", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_start",    32'(bist_start),     0);
    chk("midrst_busy",     32'(busy),           0);
    chk("midrst_valid",    32'(result_valid),   0);
    chk("midrst_pass",     32'(result_pass),    0);
    chk("midrst_timeout",  32'(result_timeout), 0);
    chk("midrst_retried",  32'(result_retried), 0);
    chk("midrst_run_cnt",  32'(run_cnt),        0);
    chk("midrst_fail_cnt", 32'(fail_cnt),       0);
    mrun  = 0;
    mfail = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("no_start_after_rst", 32'(bist_start), 0);
    end
    wait_quiet("resp_idle_wait");
    repeat (3) @(negedge clk);

    run_session(1'b0, 7, 1'b0, 0, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_time_limit: got expired expected finish");
    $fatal(1, "time limit");
  end

endmodule
